// File: rtl/table_sram_ctrl_pkg.sv
// Shared sizing, FSM state and command types for the table SRAM controller.
package table_sram_ctrl_pkg;

  localparam int NUM_WORDS = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              id;
  } cmd_t;

  // Table index increment that wraps at the table depth.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] v);
    return (v == ADDR_W'(NUM_WORDS - 1)) ? '0 : v + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/sram1rw256x64.sv
// Behavioural model of the single-port 256x64 SRAM macro: synchronous
// write, registered read data, output forced low when OEB is high.
module SRAM1RW256x64 (
  input  logic        CE,
  input  logic        WEB,
  input  logic        OEB,
  input  logic        CSB,
  input  logic [7:0]  A,
  input  logic [63:0] I,
  output logic [63:0] O
);

  logic [63:0] mem [0:255];
  logic [63:0] o_reg;

  always_ff @(posedge CE) begin
    if (!CSB) begin
      if (!WEB) mem[A] <= I;
      else      o_reg  <= mem[A];
    end
  end

  assign O = OEB ? '0 : o_reg;

endmodule

// File: rtl/table_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module table_rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_reg;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_reg ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     last_reg <= 1'b1;
    else if (|grant)  last_reg <= grant[1];
  end

endmodule

// File: rtl/table_sram_ctrl.sv
// Two-requester front end for a 256x64 table SRAM with a background clear
// engine that zero-fills the whole table after reset or on request.
module table_sram_ctrl #(
  parameter int NUM_WORDS = table_sram_ctrl_pkg::NUM_WORDS,
  parameter int ADDR_W    = table_sram_ctrl_pkg::ADDR_W,
  parameter int DATA_W    = table_sram_ctrl_pkg::DATA_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic                resp_id,
  output logic [DATA_W-1:0]   resp_rdata,
  input  logic                clear_req,
  output logic                busy
);

  import table_sram_ctrl_pkg::state_t;
  import table_sram_ctrl_pkg::ST_INIT;
  import table_sram_ctrl_pkg::ST_RUN;
  import table_sram_ctrl_pkg::cmd_t;
  import table_sram_ctrl_pkg::wrap_inc;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              clr_we;
  cmd_t              cmd_reg, cmd_next;
  logic              cmd_valid_reg;
  logic              resp_valid_reg, resp_id_reg;
  logic [1:0]        grant;
  logic              sel_id;

  logic [ADDR_W-1:0] addr_arr  [2];
  logic [DATA_W-1:0] wdata_arr [2];

  logic              sram_csb, sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_i, sram_o;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  table_rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (state_reg == ST_RUN),
    .req     (req_valid),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign sel_id    = grant[1];

  always_comb begin
    cmd_next.we    = req_we[sel_id];
    cmd_next.addr  = addr_arr[sel_id];
    cmd_next.wdata = wdata_arr[sel_id];
    cmd_next.id    = sel_id;
  end

  // Clear writes stall while an accepted command is still occupying the port.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    clr_we       = 1'b0;
    case (state_reg)
      ST_INIT: begin
        if (!cmd_valid_reg) begin
          clr_we       = 1'b1;
          clr_cnt_next = wrap_inc(clr_cnt_reg);
          if (clr_cnt_reg == ADDR_W'(NUM_WORDS - 1)) state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_req) state_next = ST_INIT;
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_INIT;
      clr_cnt_reg    <= '0;
      cmd_valid_reg  <= 1'b0;
      cmd_reg        <= '0;
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_cnt_reg    <= clr_cnt_next;
      cmd_valid_reg  <= |grant;
      if (|grant) cmd_reg <= cmd_next;
      resp_valid_reg <= cmd_valid_reg && !cmd_reg.we;
      if (cmd_valid_reg && !cmd_reg.we) resp_id_reg <= cmd_reg.id;
    end
  end

  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_a   = cmd_reg.addr;
    sram_i   = cmd_reg.wdata;
    if (cmd_valid_reg) begin
      sram_csb = 1'b0;
      sram_web = ~cmd_reg.we;
    end else if (clr_we) begin
      sram_csb = 1'b0;
      sram_web = 1'b0;
      sram_a   = clr_cnt_reg;
      sram_i   = '0;
    end
  end

  SRAM1RW256x64 u_sram (
    .CE  (clock),
    .WEB (sram_web),
    .OEB (1'b0),
    .CSB (sram_csb),
    .A   (sram_a),
    .I   (sram_i),
    .O   (sram_o)
  );

  assign resp_valid = resp_valid_reg;
  assign resp_id    = resp_id_reg;
  assign resp_rdata = sram_o;
  assign busy       = (state_reg == ST_INIT);

endmodule

// File: tb/tb_table_sram_ctrl.sv
// Directed bench for table_sram_ctrl: vector table of single transactions plus
// hand sequences for back-to-back access, arbitration, clear and reset abort.
module tb_table_sram_ctrl;

  logic         clock;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_we;
  logic [15:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_id;
  logic [63:0]  resp_rdata;
  logic         clear_req;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  table_sram_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_rdata (resp_rdata),
    .clear_req  (clear_req),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    int          id;
    logic [7:0]  addr;
    logic [63:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int id, input logic we, input logic [7:0] addr, input logic [63:0] d);
    req_valid[id]           = 1'b1;
    req_we[id]              = we;
    req_addr[id*8 +: 8]     = addr;
    req_wdata[id*64 +: 64]  = d;
  endtask

  // One isolated transaction: grant, accept, then response (or none) two edges later.
  task automatic do_txn(input vec_t v, input string tag);
    logic [1:0] exp_rdy;
    exp_rdy = (v.id == 0) ? 2'b01 : 2'b10;
    drive(v.id, v.we, v.addr, v.data);
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    step();
    req_valid = 2'b00;
    chk({tag, "_resp_early"}, 64'(resp_valid), 64'(0));
    step();
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(!v.we));
    if (!v.we) begin
      chk({tag, "_resp_id"}, 64'(resp_id), 64'(v.id));
      chk({tag, "_rdata"}, resp_rdata, v.data);
    end
    $display("%s: id=%0d we=%0d addr=%h data=%h", tag, v.id, v.we, v.addr, v.data);
  endtask

  // Counts busy cycles from the current sample point; optionally pulses clear_req.
  task automatic busy_len(input int pulse_at, output int cnt, output int stale);
    cnt   = 0;
    stale = 0;
    while (busy && cnt < 600) begin
      clear_req = (cnt == pulse_at);
      cnt++;
      step();
      if (resp_valid) stale++;
    end
    clear_req = 1'b0;
  endtask

  localparam logic [63:0] D10 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D20 = 64'h2222_2222_2222_2222;

  initial begin
    int   cnt;
    int   stale;
    vec_t v;

    vecs[0]  = '{1'b0, 1, 8'h80, 64'h0};
    vecs[1]  = '{1'b1, 0, 8'h05, 64'hDEAD_BEEF_0000_0001};
    vecs[2]  = '{1'b0, 1, 8'h05, 64'hDEAD_BEEF_0000_0001};
    vecs[3]  = '{1'b1, 1, 8'h00, 64'h0123_4567_89AB_CDEF};
    vecs[4]  = '{1'b1, 0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5]  = '{1'b0, 0, 8'h00, 64'h0123_4567_89AB_CDEF};
    vecs[6]  = '{1'b0, 1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7]  = '{1'b1, 1, 8'h05, 64'h0000_0000_CAFE_F00D};
    vecs[8]  = '{1'b0, 0, 8'h05, 64'h0000_0000_CAFE_F00D};
    vecs[9]  = '{1'b0, 0, 8'h06, 64'h0};
    vecs[10] = '{1'b1, 0, 8'h10, D10};
    vecs[11] = '{1'b0, 1, 8'h10, D10};

    reset_n   = 1'b0;
    clear_req = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));

    // Initial clear after release
    req_valid = 2'b00;
    reset_n   = 1'b1;
    busy_len(-1, cnt, stale);
    chk("init_busy_len", 64'(cnt), 64'(256));
    chk("init_stale_resp", 64'(stale), 64'(0));

    for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Write then read of the same address on consecutive cycles
    drive(0, 1'b1, 8'h05, 64'hDEAD_BEEF_0000_0001);
    #1;
    chk("b2b_wr_ready", 64'(req_ready), 64'(2'b01));
    step();
    drive(0, 1'b0, 8'h05, 64'h0);
    #1;
    chk("b2b_rd_ready", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b00;
    chk("b2b_no_wr_resp", 64'(resp_valid), 64'(0));
    step();
    chk("b2b_resp_valid", 64'(resp_valid), 64'(1));
    chk("b2b_resp_id", 64'(resp_id), 64'(0));
    chk("b2b_rdata", resp_rdata, 64'hDEAD_BEEF_0000_0001);
    $display("b2b: wr/rd addr=05 rdata=%h", resp_rdata);

    // Leave requester 1 as last grant so requester 0 wins the first tie
    v = '{1'b1, 1, 8'h20, D20};
    do_txn(v, "wr20");

    // Both requesters reading continuously
    drive(0, 1'b0, 8'h10, 64'h0);
    drive(1, 1'b0, 8'h20, 64'h0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr_grant%0d", c), 64'(req_ready), 64'((c % 2 == 0) ? 2'b01 : 2'b10));
      step();
      if (c >= 1) begin
        chk($sformatf("rr_valid%0d", c - 1), 64'(resp_valid), 64'(1));
        chk($sformatf("rr_id%0d", c - 1), 64'(resp_id), 64'((c - 1) % 2));
        chk($sformatf("rr_rdata%0d", c - 1), resp_rdata, ((c - 1) % 2 == 0) ? D10 : D20);
      end
      $display("rr cycle %0d: grant=%b", c, req_ready);
    end
    req_valid = 2'b00;
    step();
    chk("rr_valid5", 64'(resp_valid), 64'(1));
    chk("rr_id5", 64'(resp_id), 64'(1));
    chk("rr_rdata5", resp_rdata, D20);
    step();
    chk("rr_drain", 64'(resp_valid), 64'(0));

    // Clear with a read already accepted
    drive(0, 1'b0, 8'hFF, 64'h0);
    #1;
    chk("clr_rd_ready", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b00;
    clear_req = 1'b1;
    #1;
    chk("clr_busy_before", 64'(busy), 64'(0));
    step();
    clear_req = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("clr_busy", 64'(busy), 64'(1));
    chk("clr_ready_low", 64'(req_ready), 64'(0));
    chk("clr_inflight_valid", 64'(resp_valid), 64'(1));
    chk("clr_inflight_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    req_valid = 2'b00;
    busy_len(50, cnt, stale);
    chk("clr_busy_len", 64'(cnt), 64'(256));
    chk("clr_stale_resp", 64'(stale), 64'(0));
    $display("clear: busy cycles=%0d", cnt);
    v = '{1'b0, 0, 8'hFF, 64'h0};
    do_txn(v, "clr_rdFF");
    v = '{1'b0, 1, 8'h05, 64'h0};
    do_txn(v, "clr_rd05");

    // Reset aborting an in-flight read, then reset again at INIT count 100
    v = '{1'b1, 0, 8'hC8, 64'hAAAA_5555_AAAA_5555};
    do_txn(v, "wrC8");
    drive(1, 1'b0, 8'hC8, 64'h0);
    step();
    req_valid = 2'b00;
    reset_n   = 1'b0;
    #1;
    chk("abort_resp_valid", 64'(resp_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(1));
    step();
    chk("abort_no_stale", 64'(resp_valid), 64'(0));
    reset_n = 1'b1;
    stale   = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (resp_valid) stale++;
    end
    chk("abort_init_stale", 64'(stale), 64'(0));
    chk("mid_init_busy", 64'(busy), 64'(1));
    reset_n   = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rst100_ready", 64'(req_ready), 64'(0));
    chk("rst100_resp_valid", 64'(resp_valid), 64'(0));
    step();
    req_valid = 2'b00;
    reset_n   = 1'b1;
    busy_len(-1, cnt, stale);
    chk("rst100_busy_len", 64'(cnt), 64'(256));
    chk("rst100_stale_resp", 64'(stale), 64'(0));
    $display("reset at count 100: busy cycles=%0d", cnt);
    v = '{1'b0, 1, 8'hC8, 64'h0};
    do_txn(v, "rst_rdC8");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
